// File: rtl/seg_scan_capture_if.sv
// Scan-bus capture interface: raw digit-select/segment lines in, decoded frame and status out.
interface seg_scan_capture_if;
   logic [7:0]  sel_in;
   logic [6:0]  seg_in;
   logic [31:0] digits;
   logic [7:0]  blank_mask;
   logic        frame_valid;
   logic        err_sel;
   logic        err_seg;
   logic        stalled;

   // Scan source / checker side
   modport master (
      output sel_in, seg_in,
      input  digits, blank_mask, frame_valid, err_sel, err_seg, stalled
   );

   // Decoder side
   modport slave (
      input  sel_in, seg_in,
      output digits, blank_mask, frame_valid, err_sel, err_seg, stalled
   );
endinterface

// File: rtl/seg_scan_capture.sv
// Receive-side decoder for the 8-digit multiplexed seven-segment scan bus.
// Waits for each scanned vector to settle, decodes it into a shadow frame and
// commits the frame once every digit has been seen.
module seg_scan_capture #(
   parameter int unsigned SETTLE  = 4,
   parameter int unsigned TIMEOUT = 20000
) (
   input  logic              clk,
   input  logic              rst,
   seg_scan_capture_if.slave bus
);

   localparam int unsigned SEL_W = 8;
   localparam int unsigned SEG_W = 7;
   localparam int unsigned VEC_W = SEL_W + SEG_W;
   localparam int unsigned CNT_W = $clog2(SETTLE + 1);
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   // Count holds matching sample pairs, so SETTLE samples means SETTLE-1 matches.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0] CNT_ARM  = CNT_W'(SETTLE - 2);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

   logic [VEC_W-1:0] vec_q, prev_q, cap_vec_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cap_q, cap_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             stalled_q, stalled_d;
   logic [7:0]       seen_q, seen_d;
   logic [31:0]      shadow_q, shadow_d;
   logic [7:0]       shblank_q, shblank_d;
   logic [31:0]      digits_q, digits_d;
   logic [7:0]       blank_q, blank_d;
   logic             fv_q, fv_d;
   logic             err_sel_q, err_sel_d;
   logic             err_seg_q, err_seg_d;

   logic [SEL_W-1:0] cap_sel_c;
   logic [SEG_W-1:0] cap_seg_c;
   logic [3:0]       dec_nib_c;
   logic             dec_blank_c;
   logic             dec_bad_c;
   logic             cap_onehot_c;

   assign cap_sel_c = cap_vec_q[VEC_W-1:SEG_W];
   assign cap_seg_c = cap_vec_q[SEG_W-1:0];

   // Input sampling: one register stage plus the previous sample for comparison
   always_ff @(posedge clk) begin
      if (rst) begin
         vec_q  <= '0;
         prev_q <= '0;
      end else begin
         vec_q  <= {bus.sel_in, bus.seg_in};
         prev_q <= vec_q;
      end
   end

   // Stability counter; capture fires once, on the match that completes SETTLE samples
   always_comb begin
      cnt_d = cnt_q;
      cap_d = 1'b0;
      if (vec_q != prev_q) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_LAST) begin
         cnt_d = cnt_q + CNT_W'(1);
         cap_d = (cnt_q == CNT_ARM);
      end
   end

   // Stability counter and captured vector registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         cap_q     <= 1'b0;
         cap_vec_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         cap_q <= cap_d;
         if (cap_d) begin
            cap_vec_q <= vec_q;
         end
      end
   end

   // Segment pattern (a..g) to hex nibble; dark digit decodes to 0 with blank set
   always_comb begin
      dec_nib_c   = 4'h0;
      dec_blank_c = 1'b0;
      dec_bad_c   = 1'b0;
      case (cap_seg_c)
         7'b1111110: dec_nib_c = 4'h0;
         7'b0110000: dec_nib_c = 4'h1;
         7'b1101101: dec_nib_c = 4'h2;
         7'b1111001: dec_nib_c = 4'h3;
         7'b0110011: dec_nib_c = 4'h4;
         7'b1011011: dec_nib_c = 4'h5;
         7'b1011111: dec_nib_c = 4'h6;
         7'b1110000: dec_nib_c = 4'h7;
         7'b1111111: dec_nib_c = 4'h8;
         7'b1111011: dec_nib_c = 4'h9;
         7'b1110111: dec_nib_c = 4'hA;
         7'b0011111: dec_nib_c = 4'hB;
         7'b1001110: dec_nib_c = 4'hC;
         7'b0111101: dec_nib_c = 4'hD;
         7'b1001111: dec_nib_c = 4'hE;
         7'b1000111: dec_nib_c = 4'hF;
         7'b0000000: dec_blank_c = 1'b1;
         default: begin
            dec_nib_c = 4'hF;
            dec_bad_c = 1'b1;
         end
      endcase
   end

   assign cap_onehot_c = cap_q && $onehot(cap_sel_c);

   // Capture processing: shadow update, frame commit, error pulses and stall tracking
   always_comb begin
      seen_d    = seen_q;
      shadow_d  = shadow_q;
      shblank_d = shblank_q;
      digits_d  = digits_q;
      blank_d   = blank_q;
      fv_d      = 1'b0;
      err_sel_d = cap_q && (cap_sel_c != '0) && !$onehot(cap_sel_c);
      err_seg_d = 1'b0;
      tmo_d     = tmo_q;
      stalled_d = stalled_q;
      if (cap_onehot_c) begin
         for (int b = 0; b < 8; b++) begin
            if (cap_sel_c[b]) begin
               shadow_d[4*b +: 4] = dec_nib_c;
               shblank_d[b]       = dec_blank_c;
            end
         end
         seen_d    = seen_q | cap_sel_c;
         err_seg_d = dec_bad_c;
         tmo_d     = '0;
         stalled_d = 1'b0;
         if (seen_d == 8'hFF) begin
            digits_d = shadow_d;
            blank_d  = shblank_d;
            fv_d     = 1'b1;
            seen_d   = '0;
         end
      end else begin
         // Blanking and bad-select captures neither feed the frame nor reset the timeout
         if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + TMO_W'(1);
         end
         if (tmo_d == TMO_MAX) begin
            stalled_d = 1'b1;
            seen_d    = '0;
         end
      end
   end

   // Frame, shadow and status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         seen_q    <= '0;
         shadow_q  <= '0;
         shblank_q <= '0;
         digits_q  <= '0;
         blank_q   <= 8'hFF;
         fv_q      <= 1'b0;
         err_sel_q <= 1'b0;
         err_seg_q <= 1'b0;
         tmo_q     <= '0;
         stalled_q <= 1'b0;
      end else begin
         seen_q    <= seen_d;
         shadow_q  <= shadow_d;
         shblank_q <= shblank_d;
         digits_q  <= digits_d;
         blank_q   <= blank_d;
         fv_q      <= fv_d;
         err_sel_q <= err_sel_d;
         err_seg_q <= err_seg_d;
         tmo_q     <= tmo_d;
         stalled_q <= stalled_d;
      end
   end

   assign bus.digits      = digits_q;
   assign bus.blank_mask  = blank_q;
   assign bus.frame_valid = fv_q;
   assign bus.err_sel     = err_sel_q;
   assign bus.err_seg     = err_seg_q;
   assign bus.stalled     = stalled_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: reference model checked every cycle, frame table,
// directed corner sequences and randomized scan traffic.
module tb_seg_scan_capture;

   localparam int SET = 4;
   localparam int TMO = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seg_scan_capture_if bus ();

   seg_scan_capture #(.SETTLE(SET), .TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [6:0] seg_tab [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   typedef struct {
      logic [31:0] chars;     // hex digit shown, digit 0 in [31:28]
      logic [7:0]  dark;      // digits sent with all segments off (sel bit order)
      logic [7:0]  bad;       // digits sent with an undecodable pattern (sel bit order)
      logic [31:0] exp_digits;
      logic [7:0]  exp_blank;
      int          exp_fv;
      int          exp_esel;
      int          exp_eseg;
   } frame_vec_t;

   frame_vec_t tbl [5];

   int n_chk  = 0;
   int n_fail = 0;
   int fv_cnt, esel_cnt, eseg_cnt;

   // Reference model state
   logic [31:0] m_digits;
   logic [7:0]  m_blank, m_seen, m_shb;
   logic [3:0]  m_shadow [8];
   logic        m_fv, m_esel, m_eseg, m_stalled;
   int          m_since, run_len;
   logic [14:0] last_v, d1_v, d2_v;
   logic        d1, d2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model of one clock edge: a vector becomes visible two edges after its SETTLE-th sample
   task automatic model_edge(input logic [14:0] v, input logic r);
      logic        cap, onehot;
      logic [14:0] cv;
      logic [3:0]  nib;
      logic        blk, found;
      int          b;
      if (r) begin
         m_digits = '0; m_blank = 8'hFF; m_fv = 0; m_esel = 0; m_eseg = 0; m_stalled = 0;
         m_seen = '0; m_shb = '0; m_since = 0;
         for (int i = 0; i < 8; i++) m_shadow[i] = 4'h0;
         last_v = '0; run_len = SET + 1; d1 = 0; d2 = 0; d1_v = '0; d2_v = '0;
      end else begin
         m_fv = 0; m_esel = 0; m_eseg = 0;
         cap = d2; cv = d2_v; d2 = d1; d2_v = d1_v; d1 = 0;
         if (v == last_v) begin
            if (run_len <= SET) run_len++;
         end else begin
            last_v = v; run_len = 1;
         end
         if (run_len == SET) begin
            d1 = 1; d1_v = v;
         end
         onehot = cap && ($countones(cv[14:7]) == 1);
         if (cap && cv[14:7] != 8'h00 && !onehot) m_esel = 1;
         if (onehot) begin
            b = 0;
            for (int i = 0; i < 8; i++) if (cv[7+i]) b = i;
            nib = 4'h0; blk = 0; found = 0;
            if (cv[6:0] == 7'b0) begin
               blk = 1;
            end else begin
               for (int n = 0; n < 16; n++) begin
                  if (seg_tab[n] == cv[6:0]) begin
                     nib = 4'(n); found = 1;
                  end
               end
               if (!found) begin
                  nib = 4'hF; m_eseg = 1;
               end
            end
            m_shadow[b] = nib; m_shb[b] = blk; m_seen[b] = 1'b1;
            m_since = 0; m_stalled = 0;
            if (m_seen == 8'hFF) begin
               for (int i = 0; i < 8; i++) m_digits[4*i +: 4] = m_shadow[i];
               m_blank = m_shb; m_fv = 1; m_seen = '0;
            end
         end else begin
            if (m_since < TMO) m_since++;
            if (m_since == TMO) begin
               m_stalled = 1; m_seen = '0;
            end
         end
      end
   endtask

   // One clock: drive at negedge, model at posedge, compare at next negedge
   task automatic step(input logic [7:0] s, input logic [6:0] g);
      bus.sel_in = s;
      bus.seg_in = g;
      @(posedge clk);
      model_edge({s, g}, rst);
      @(negedge clk);
      chk("digits",      bus.digits,              m_digits);
      chk("blank_mask",  32'(bus.blank_mask),     32'(m_blank));
      chk("frame_valid", 32'(bus.frame_valid),    32'(m_fv));
      chk("err_sel",     32'(bus.err_sel),        32'(m_esel));
      chk("err_seg",     32'(bus.err_seg),        32'(m_eseg));
      chk("stalled",     32'(bus.stalled),        32'(m_stalled));
      fv_cnt   += int'(bus.frame_valid);
      esel_cnt += int'(bus.err_sel);
      eseg_cnt += int'(bus.err_seg);
   endtask

   task automatic clr_cnt();
      fv_cnt = 0; esel_cnt = 0; eseg_cnt = 0;
   endtask

   // Digit d held 8 cycles, then 2 cycles of blanking
   task automatic scan_digit(input int d, input logic [6:0] g);
      repeat (8) step(8'(8'h80 >> d), g);
      repeat (2) step(8'h00, 7'h00);
   endtask

   function automatic logic [6:0] seg_hex(input logic [31:0] chars, input int d);
      logic [3:0] n;
      n = chars[4*(7-d) +: 4];
      return seg_tab[n];
   endfunction

   function automatic logic [6:0] seg_rec(input frame_vec_t r, input int d);
      if (r.dark[7-d]) return 7'b0000000;
      if (r.bad[7-d])  return 7'b1010101;
      return seg_hex(r.chars, d);
   endfunction

   initial begin
      logic [7:0] rs;
      logic [6:0] rg;
      int         kind, hold, a, b;

      tbl[0] = '{32'h6801_1002, 8'h00, 8'h00, 32'h6801_1002, 8'h00, 1, 0, 0};
      tbl[1] = '{32'h1234_5678, 8'h81, 8'h00, 32'h0234_5670, 8'h81, 1, 0, 0};
      tbl[2] = '{32'h9ABC_DEF0, 8'h00, 8'h20, 32'h9AFC_DEF0, 8'h00, 1, 0, 1};
      tbl[3] = '{32'h89AB_CDEF, 8'h00, 8'h00, 32'h89AB_CDEF, 8'h00, 1, 0, 0};
      tbl[4] = '{32'h0000_0000, 8'hFF, 8'h00, 32'h0000_0000, 8'hFF, 1, 0, 0};

      bus.sel_in = 8'h00;
      bus.seg_in = 7'h00;
      clr_cnt();
      @(negedge clk);
      rst = 1'b1;
      step(8'h00, 7'h00);
      chk("rst_digits", bus.digits, 32'h0);
      chk("rst_blank",  32'(bus.blank_mask), 32'hFF);
      chk("rst_stalled", 32'(bus.stalled), 32'h0);
      step(8'h00, 7'h00);
      rst = 1'b0;

      // Frame table
      for (int i = 0; i < 5; i++) begin
         clr_cnt();
         for (int d = 0; d < 8; d++) scan_digit(d, seg_rec(tbl[i], d));
         chk("tbl_digits", bus.digits, tbl[i].exp_digits);
         chk("tbl_blank",  32'(bus.blank_mask), 32'(tbl[i].exp_blank));
         chk("tbl_fv_cnt", 32'(fv_cnt), 32'(tbl[i].exp_fv));
         chk("tbl_esel_cnt", 32'(esel_cnt), 32'(tbl[i].exp_esel));
         chk("tbl_eseg_cnt", 32'(eseg_cnt), 32'(tbl[i].exp_eseg));
      end

      // Short glitch on digit 1 is not captured; frame stays incomplete
      clr_cnt();
      for (int d = 0; d < 8; d++) begin
         if (d == 1) begin
            repeat (3) step(8'h40, 7'b1111111);
            repeat (2) step(8'h00, 7'h00);
         end else begin
            scan_digit(d, seg_hex(32'h1234_5678, d));
         end
      end
      chk("glitch_no_fv", 32'(fv_cnt), 32'd0);
      scan_digit(1, seg_hex(32'h1234_5678, 1));
      chk("glitch_fv", 32'(fv_cnt), 32'd1);
      chk("glitch_digits", bus.digits, 32'h1234_5678);

      // Multi-hot select: one err_sel pulse and no effect on the frame
      clr_cnt();
      for (int d = 0; d < 7; d++) scan_digit(d, seg_hex(32'hCAFE_BABE, d));
      repeat (8) step(8'h81, seg_tab[1]);
      repeat (2) step(8'h00, 7'h00);
      chk("esel_no_fv", 32'(fv_cnt), 32'd0);
      chk("esel_cnt", 32'(esel_cnt), 32'd1);
      scan_digit(7, seg_hex(32'hCAFE_BABE, 7));
      chk("esel_fv", 32'(fv_cnt), 32'd1);
      chk("esel_digits", bus.digits, 32'hCAFE_BABE);
      chk("esel_eseg", 32'(eseg_cnt), 32'd0);

      // Stall after 5 digits, then a fresh scan needs all 8 digits
      for (int d = 0; d < 5; d++) scan_digit(d, seg_hex(32'hDEAD_BEEF, d));
      chk("pre_stall", 32'(bus.stalled), 32'd0);
      repeat (64) step(8'h00, 7'h00);
      chk("stalled", 32'(bus.stalled), 32'd1);
      chk("stall_digits", bus.digits, 32'hCAFE_BABE);
      clr_cnt();
      scan_digit(5, seg_hex(32'h0123_4567, 5));
      chk("stall_drop", 32'(bus.stalled), 32'd0);
      scan_digit(6, seg_hex(32'h0123_4567, 6));
      scan_digit(7, seg_hex(32'h0123_4567, 7));
      chk("stall_no_fv", 32'(fv_cnt), 32'd0);
      for (int d = 0; d < 5; d++) scan_digit(d, seg_hex(32'h0123_4567, d));
      chk("stall_fv", 32'(fv_cnt), 32'd1);
      chk("stall_new_digits", bus.digits, 32'h0123_4567);

      // Reset mid-frame discards the partial frame
      for (int d = 0; d < 6; d++) scan_digit(d, seg_hex(32'h7654_3210, d));
      rst = 1'b1;
      step(8'h00, 7'h00);
      chk("mid_rst_digits", bus.digits, 32'h0);
      chk("mid_rst_blank",  32'(bus.blank_mask), 32'hFF);
      chk("mid_rst_fv",     32'(bus.frame_valid), 32'h0);
      step(8'h00, 7'h00);
      rst = 1'b0;
      clr_cnt();
      scan_digit(6, seg_hex(32'h7654_3210, 6));
      scan_digit(7, seg_hex(32'h7654_3210, 7));
      chk("rst_no_fv", 32'(fv_cnt), 32'd0);
      for (int d = 0; d < 6; d++) scan_digit(d, seg_hex(32'h7654_3210, d));
      chk("rst_fv", 32'(fv_cnt), 32'd1);
      chk("rst_new_digits", bus.digits, 32'h7654_3210);

      // Randomized scan traffic against the model
      for (int n = 0; n < 400; n++) begin
         kind = int'($urandom_range(0, 9));
         hold = int'($urandom_range(1, 8));
         rs = 8'h00;
         rg = seg_tab[$urandom_range(0, 15)];
         if (kind <= 5 || kind == 9) begin
            rs = 8'(8'h01 << $urandom_range(0, 7));
            if (kind == 9) rg = 7'($urandom);
            else if (kind == 5) rg = 7'h00;
         end else if (kind == 8) begin
            a = int'($urandom_range(0, 7));
            b = (a + int'($urandom_range(1, 7))) % 8;
            rs = 8'((8'h01 << a) | (8'h01 << b));
         end
         repeat (hold) step(rs, rg);
         if (n == 200) repeat (70) step(8'h00, 7'h00);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Receive-side decoder for the multiplexed 8-digit seven-segment scan bus that the display drivers generate. It watches the one-hot digit-select and segment lines, waits for each scanned vector to settle, and decodes the segment pattern to a hex nibble. It assembles a full 8-digit frame and presents it as a parallel word with a one-cycle frame strobe. It sits on the board-test and self-check path, fed from the same scan bus that drives the physical display.

## Interface
- SETTLE, 4, number of consecutive identical samples required before a vector is captured (>=2)
- TIMEOUT, 20000, cycles without any capture before the scan is declared stalled (>=SETTLE+2)
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- sel_in  input  8  digit select, one-hot; bit 7 = digit 0 (leftmost), bit 0 = digit 7
- seg_in  input  7  segments, bit 6 = a … bit 0 = g, 1 = lit
- digits  output  32  decoded frame; [31:28] = digit 0 … [3:0] = digit 7
- blank_mask  output  8  1 = digit was dark (seg 0000000); same bit order as sel_in
- frame_valid  output  1  one-cycle pulse when digits/blank_mask update
- err_sel  output  1  one-cycle pulse: settled vector had sel_in with more than one bit set
- err_seg  output  1  one-cycle pulse: settled segment pattern not in decode table
- stalled  output  1  level; high while no capture for TIMEOUT cycles

## Operation
- Inputs are registered once, then compared each cycle with the previous registered value. A stability counter clears on mismatch, increments on match, and saturates at SETTLE.
- Capture fires once per stable vector, on the sample that brings the count to SETTLE. A vector is never recaptured until it changes.
- At capture:
  - sel == 0: blanking interval. Ignored, no error, timeout counter not cleared.
  - sel not one-hot: err_sel pulse, nothing stored.
  - sel one-hot: decode seg, write the nibble and blank bit into the shadow slot for that digit, and set that digit's seen bit.
- Decode table, patterns a..g:
  - 0 1111110, 1 0110000, 2 1101101, 3 1111001, 4 0110011, 5 1011011, 6 1011111, 7 1110000
  - 8 1111111, 9 1111011, A 1110111, b 0011111, C 1001110, d 0111101, E 1001111, F 1000111
  - 0000000 → nibble 0, blank bit 1.
  - Any other pattern → nibble F, blank bit 0, err_seg pulse, seen bit still set.
- Recapture of an already-seen digit overwrites its shadow slot.
- When seen becomes 8'hFF (including the current capture), copy the shadow to digits/blank_mask, pulse frame_valid, and clear seen.
- Timeout counter clears on every one-hot capture and saturates at TIMEOUT. On reaching TIMEOUT: stalled = 1, seen cleared, shadow kept. stalled drops on the next one-hot capture.
- digits and blank_mask hold their last committed frame between frames and during a stall.

## Timing
- Reset values:
  - digits 32'h0, blank_mask 8'hFF, frame_valid 0, err_sel 0, err_seg 0, stalled 0
  - all counters, seen, and shadow cleared
- Latency: vector applied before edge k and held through edge k+SETTLE-1. The capture decision is registered at edge k+SETTLE. err_sel/err_seg are high for the cycle after edge k+SETTLE+1.
- Frame completion: digits, blank_mask, and frame_valid update at edge k+SETTLE+1 of the completing capture. frame_valid is high for exactly that one cycle.
- A vector held fewer than SETTLE samples is never captured, which gives glitch immunity.
- A capture on the same edge that the timeout expires is processed as a capture: stalled stays 0 and the timeout counter clears.
- rst mid-frame discards the partial frame. Outputs return to reset values on the next edge.

## Test plan
- SETTLE=4, TIMEOUT=64. Scan "68011002", sel 0x80→0x01, each vector held 8 cycles with 2 cycles of sel=0 between digits → after the 8th digit, exactly one frame_valid; digits=32'h6801_1002, blank_mask=8'h00; no error pulses.
- Vector 0x40/1111111 held 3 cycles, then changed → no capture. A frame missing that digit never asserts frame_valid.
- sel=0x81 held 8 cycles → single err_sel pulse, seen unchanged. seg=1010101 on digit 2 → err_seg pulse; next frame has digits[23:20]=4'hF.
- seg=0000000 on digits 0 and 7 in an otherwise "12345678" frame → digits=32'h0234_5670, blank_mask=8'h81.
- Stop the scan after 5 digits and idle 64 cycles → stalled=1, digits unchanged. A new full scan → stalled drops at the first capture; frame_valid only after all 8 new digits.
- Assert rst after 6 digits → all outputs return to reset values. A following full scan produces a correct frame; no frame_valid from the pre-reset partial frame.
